// File: rtl/au_addsub_pipe.sv
// au_addsub_pipe: pipelined adder-subtractor resolving one LSB-first segment per stage,
// with valid/ready flow control, carry/borrow-out and two's-complement overflow.
module au_addsub_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             add_sub,
    input  logic             ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ov
);
    localparam int NS = (STAGES < 1) ? 1 : STAGES;
    localparam int Q  = WIDTH / NS;
    localparam int R  = WIDTH % NS;

    if (WIDTH < 1 || STAGES < 1 || STAGES > WIDTH) begin : g_bad_param
        $fatal(1, "au_addsub_pipe: invalid WIDTH=%0d STAGES=%0d", WIDTH, STAGES);
    end

    logic w_adv;

    assign w_adv    = ~out_valid | out_ready;
    assign in_ready = w_adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        localparam int WK = (k < R) ? Q + 1 : Q;
        localparam int LO = k * Q + ((k < R) ? k : R);
        localparam int HI = LO + WK;
        // Operand bits not yet consumed; bit 0 is the LSB of this stage's segment.
        logic [WIDTH-LO-1:0] w_a;
        logic [WIDTH-LO-1:0] w_bx;
        logic                w_v;
        logic                w_c;
        logic                w_sub;
        logic [WK:0]         w_seg;
        logic [HI-1:0]       w_snext;
        logic                r_v;
        logic [HI-1:0]       r_s;

        if (k == 0) begin : g_in
            assign w_a     = a;
            assign w_bx    = add_sub ? ~b : b;
            assign w_c     = add_sub ^ ci;
            assign w_sub   = add_sub;
            assign w_v     = in_valid;
            assign w_snext = w_seg[WK-1:0];
        end else begin : g_in
            assign w_a     = g_st[k-1].g_mid.r_a;
            assign w_bx    = g_st[k-1].g_mid.r_bx;
            assign w_c     = g_st[k-1].g_mid.r_c;
            assign w_sub   = g_st[k-1].g_mid.r_sub;
            assign w_v     = g_st[k-1].r_v;
            assign w_snext = {w_seg[WK-1:0], g_st[k-1].r_s};
        end

        assign w_seg = {1'b0, w_a[WK-1:0]} + {1'b0, w_bx[WK-1:0]} + {{WK{1'b0}}, w_c};

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_v <= 1'b0;
                r_s <= '0;
            end else if (w_adv) begin
                r_v <= w_v;
                r_s <= w_snext;
            end
        end

        if (k < STAGES - 1) begin : g_mid
            logic [WIDTH-HI-1:0] r_a;
            logic [WIDTH-HI-1:0] r_bx;
            logic                r_c;
            logic                r_sub;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_a   <= '0;
                    r_bx  <= '0;
                    r_c   <= 1'b0;
                    r_sub <= 1'b0;
                end else if (w_adv) begin
                    r_a   <= w_a[WIDTH-LO-1:WK];
                    r_bx  <= w_bx[WIDTH-LO-1:WK];
                    r_c   <= w_seg[WK];
                    r_sub <= w_sub;
                end
            end
        end else begin : g_last
            logic r_co;
            logic r_ov;

            // Carry into the MSB is recovered from the MSB sum bit and its operands.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_co <= 1'b0;
                    r_ov <= 1'b0;
                end else if (w_adv) begin
                    r_co <= w_seg[WK] ^ w_sub;
                    r_ov <= w_seg[WK] ^ w_a[WK-1] ^ w_bx[WK-1] ^ w_seg[WK-1];
                end
            end
        end
    end

    assign out_valid = g_st[STAGES-1].r_v;
    assign s         = g_st[STAGES-1].r_s;
    assign co        = g_st[STAGES-1].g_last.r_co;
    assign ov        = g_st[STAGES-1].g_last.r_ov;
endmodule
